// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner_if
// Description : Button pins in, conditioned levels and event pulses out.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_conditioner_if #(
    parameter int NUM_BTN = 4
);
    logic               ena;
    logic [NUM_BTN-1:0] btn_in;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_repeat;
    logic               any_step;

    modport master (
        output ena,
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat,
        input  any_step
    );

    modport slave (
        input  ena,
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat,
        output any_step
    );
endinterface
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Per-channel synchroniser, debounce, edge pulses and auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 50_000,
    parameter int REPEAT_DELAY    = 5_000_000,
    parameter int REPEAT_PERIOD   = 1_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    button_conditioner_if.slave bus
);
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    logic [NUM_BTN-1:0] level_vec;
    logic [NUM_BTN-1:0] press_vec;
    logic [NUM_BTN-1:0] release_vec;
    logic [NUM_BTN-1:0] repeat_vec;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        logic            sync1_q;
        logic            sync2_q;
        logic [DB_W-1:0] db_cnt_q;
        logic [DB_W-1:0] db_cnt_d;
        logic            level_q;
        logic            level_d;
        logic            press_q;
        logic            press_d;
        logic            release_q;
        logic            release_d;
        logic            rep_q;

        // Synchroniser deliberately ignores ena so the input is settled when ena returns.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
            end else begin
                sync1_q <= bus.btn_in[i];
                sync2_q <= sync1_q;
            end
        end

        always_comb begin
            db_cnt_d  = db_cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (!bus.ena) begin
                db_cnt_d = '0;
                level_d  = 1'b0;
            end else if (sync2_q == level_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d   = ~level_q;
                db_cnt_d  = '0;
                press_d   = ~level_q;
                release_d = level_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt_q  <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                db_cnt_q  <= db_cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        if (REPEAT_DELAY > 0) begin : g_repeat
            logic [RPT_W-1:0] rpt_cnt_q;
            logic [RPT_W-1:0] rpt_cnt_d;
            logic             armed_q;
            logic             armed_d;
            logic             rep_d;

            // Holding requires the level to be high both before and after this edge,
            // so the press edge and the release edge both restart the repeat state.
            always_comb begin
                rpt_cnt_d = rpt_cnt_q;
                armed_d   = armed_q;
                rep_d     = 1'b0;
                if (!bus.ena || !level_q || !level_d) begin
                    rpt_cnt_d = '0;
                    armed_d   = 1'b0;
                end else if (!armed_q) begin
                    if (rpt_cnt_q == RPT_W'(REPEAT_DELAY - 1)) begin
                        rep_d     = 1'b1;
                        armed_d   = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
                end else if (rpt_cnt_q == RPT_W'(REPEAT_PERIOD - 1)) begin
                    rep_d     = 1'b1;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rpt_cnt_q <= '0;
                    armed_q   <= 1'b0;
                    rep_q     <= 1'b0;
                end else begin
                    rpt_cnt_q <= rpt_cnt_d;
                    armed_q   <= armed_d;
                    rep_q     <= rep_d;
                end
            end
        end else begin : g_no_repeat
            assign rep_q = 1'b0;
        end

        assign level_vec[i]   = level_q;
        assign press_vec[i]   = press_q;
        assign release_vec[i] = release_q;
        assign repeat_vec[i]  = rep_q;
    end

    assign bus.btn_level   = level_vec;
    assign bus.btn_press   = press_vec;
    assign bus.btn_release = release_vec;
    assign bus.btn_repeat  = repeat_vec;
    assign bus.any_step    = |(press_vec | repeat_vec);

endmodule
`default_nettype wire
